// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART among NCH full FIFOs.
// Define UART_TX_SCHED_CHECKSUM_EN to append an XOR checksum byte per frame.
module uart_tx_sched #(
   parameter int         NCH  = 4,
   parameter int         N    = 512,
   parameter logic [3:0] SYNC = 4'hA
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   full,
   input  logic [8*NCH-1:0] fifo_q,
   input  logic             txBusy,
   output logic [NCH-1:0]   oRdclk,
   output logic             oNewData,
   output logic [7:0]       oTxData,
   output logic [NCH-1:0]   oGrant,
   output logic             oBusy
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = $clog2(N + 1);

`ifdef UART_TX_SCHED_CHECKSUM_EN
   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_GUARD, S_TXW, S_RD,
      S_RW1, S_RW2, S_LAT, S_SEND, S_DONE, S_CSUM
   } state_t;
`else
   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_GUARD, S_TXW, S_RD,
      S_RW1, S_RW2, S_LAT, S_SEND, S_DONE
   } state_t;
`endif

   state_t           r_state;
   state_t           w_nstate;
   state_t           w_tail;

   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    r_gidx;
   logic [CW-1:0]    r_cnt;
   logic [NCH-1:0]   r_grant;
   logic [NCH-1:0]   r_rdclk;
   logic             r_busy;
   logic             r_newdata;
   logic [7:0]       r_txdata;

   logic [PW-1:0]    w_ptr_n;
   logic [PW-1:0]    w_gidx_n;
   logic [CW-1:0]    w_cnt_n;
   logic [NCH-1:0]   w_grant_n;
   logic [NCH-1:0]   w_rdclk_n;
   logic             w_busy_n;
   logic             w_newdata_n;
   logic [7:0]       w_txdata_n;

   logic             w_req;
   logic [PW-1:0]    w_sel;
   logic [PW-1:0]    w_cand;
   logic [NCH-1:0]   w_selhot;
   logic [7:0]       w_qbyte;
   logic             w_more;

   // Search starts just after the last owner so every requester gets a turn.
   always_comb begin
      w_req  = 1'b0;
      w_sel  = '0;
      w_cand = '0;
      for (int i = 1; i <= NCH; i++) begin
         w_cand = PW'((int'(r_ptr) + i) % NCH);
         if (!w_req && full[w_cand]) begin
            w_req = 1'b1;
            w_sel = w_cand;
         end
      end
   end

   always_comb begin
      w_selhot = '0;
      for (int k = 0; k < NCH; k++) begin
         w_selhot[k] = (w_sel == PW'(k));
      end
   end

   always_comb begin
      w_qbyte = '0;
      for (int k = 0; k < NCH; k++) begin
         if (r_gidx == PW'(k)) begin
            w_qbyte = fifo_q[8*k +: 8];
         end
      end
   end

   assign w_more = (r_cnt < CW'(N));

`ifdef UART_TX_SCHED_CHECKSUM_EN
   logic [7:0] r_acc;
   logic       r_csum_sent;
   logic [7:0] w_acc_n;
   logic       w_csum_sent_n;

   assign w_tail = r_csum_sent ? S_DONE : S_CSUM;

   // Accumulator follows every byte placed on oTxData, header first.
   always_comb begin
      w_acc_n       = r_acc;
      w_csum_sent_n = r_csum_sent;
      if (r_state == S_IDLE && w_req) begin
         w_acc_n       = w_txdata_n;
         w_csum_sent_n = 1'b0;
      end else if (r_state == S_LAT) begin
         w_acc_n = r_acc ^ w_qbyte;
      end else if (r_state == S_CSUM) begin
         w_csum_sent_n = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_csum_sent <= 1'b0;
      end else begin
         r_acc       <= w_acc_n;
         r_csum_sent <= w_csum_sent_n;
      end
   end
`else
   assign w_tail = S_DONE;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= PW'(NCH - 1);
         r_gidx    <= '0;
         r_cnt     <= '0;
         r_grant   <= '0;
         r_rdclk   <= '0;
         r_busy    <= 1'b0;
         r_newdata <= 1'b0;
         r_txdata  <= '0;
      end else begin
         r_state   <= w_nstate;
         r_ptr     <= w_ptr_n;
         r_gidx    <= w_gidx_n;
         r_cnt     <= w_cnt_n;
         r_grant   <= w_grant_n;
         r_rdclk   <= w_rdclk_n;
         r_busy    <= w_busy_n;
         r_newdata <= w_newdata_n;
         r_txdata  <= w_txdata_n;
      end
   end

   always_comb begin
      w_nstate = r_state;
      unique case (r_state)
         S_IDLE:  if (w_req) w_nstate = S_HDR;
         S_HDR:   w_nstate = S_GUARD;
         S_GUARD: w_nstate = S_TXW;
         S_TXW: begin
            if (!txBusy) begin
               w_nstate = w_more ? S_RD : w_tail;
            end
         end
         S_RD:    w_nstate = S_RW1;
         S_RW1:   w_nstate = S_RW2;
         S_RW2:   w_nstate = S_LAT;
         S_LAT:   w_nstate = S_SEND;
         S_SEND:  w_nstate = S_GUARD;
         S_DONE:  w_nstate = S_IDLE;
`ifdef UART_TX_SCHED_CHECKSUM_EN
         S_CSUM:  w_nstate = S_SEND;
`endif
         default: w_nstate = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; strobes default low.
   always_comb begin
      w_ptr_n     = r_ptr;
      w_gidx_n    = r_gidx;
      w_cnt_n     = r_cnt;
      w_grant_n   = r_grant;
      w_rdclk_n   = '0;
      w_busy_n    = r_busy;
      w_newdata_n = 1'b0;
      w_txdata_n  = r_txdata;
      unique case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_grant_n  = w_selhot;
               w_gidx_n   = w_sel;
               w_busy_n   = 1'b1;
               w_txdata_n = {SYNC, 4'(w_sel)};
               w_cnt_n    = '0;
            end
         end
         S_HDR, S_SEND: w_newdata_n = 1'b1;
         S_RD: begin
            w_rdclk_n = r_grant;
            w_cnt_n   = r_cnt + 1'b1;
         end
         S_LAT:  w_txdata_n = w_qbyte;
         S_DONE: begin
            w_ptr_n   = r_gidx;
            w_grant_n = '0;
            w_busy_n  = 1'b0;
         end
`ifdef UART_TX_SCHED_CHECKSUM_EN
         S_CSUM: w_txdata_n = r_acc;
`endif
         default: ;
      endcase
   end

   assign oRdclk   = r_rdclk;
   assign oNewData = r_newdata;
   assign oTxData  = r_txdata;
   assign oGrant   = r_grant;
   assign oBusy    = r_busy;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares the single UART transmitter between NCH FIFO channels.
- When a channel's FIFO reports full, the block grants it the UART and sends one frame: a header byte, then exactly N data bytes drained from that FIFO.
- Sits between the per-channel acquisition FIFOs and the uart_tx instance; it replaces the per-channel drain logic.

Parameters:
- NCH, 4, number of FIFO channels; range 1..16.
- N, 512, data bytes per frame; must be ≥1.
- SYNC, 4'hA, upper nibble of the header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- full  in  NCH  per-channel FIFO full flag, level.
- fifo_q  in  8*NCH  FIFO read data; channel k occupies bits [8k+7:8k].
- txBusy  in  1  UART busy, high while a byte is shifting out.
- oRdclk  out  NCH  one-cycle read pulse to the granted FIFO.
- oNewData  out  1  one-cycle load strobe to the UART.
- oTxData  out  8  byte to transmit.
- oGrant  out  NCH  one-hot owner of the UART; all zero when idle.
- oBusy  out  1  high from grant until the frame completes.

Behaviour:
- Reset: one clock, synchronous, active-high (rst). All outputs are 0, state is IDLE, RR pointer is NCH-1 (so channel 0 wins first), byte counter is 0.
- All outputs are registered.
- Reset mid-frame aborts the frame immediately. There is no resume, and no further oRdclk or oNewData pulses occur.
- States:
  - IDLE: if any full[k] is high, select the first k searching ptr+1, ptr+2, … modulo NCH. Then load oGrant, set oBusy=1, load oTxData={SYNC,k[3:0]}, clear cnt, go to HDR. Otherwise stay in IDLE.
  - HDR: oNewData=1 for one cycle; go to GUARD.
  - GUARD: one cycle; txBusy is ignored so the UART has time to raise it; go to TXW.
  - TXW: wait for txBusy==0. Then: if cnt<N go to RD; else if CHECKSUM_EN and the checksum is not yet sent go to CSUM; else go to DONE.
  - RD: oRdclk[g]=1 for exactly one cycle; cnt<=cnt+1; go to RW1.
  - RW1: one wait cycle; go to RW2.
  - RW2: one wait cycle; go to LAT.
  - LAT: oTxData<=fifo_q[g]; go to SEND.
  - SEND: oNewData=1 for one cycle; go to GUARD.
  - DONE: ptr<=g; oGrant<=0; oBusy<=0; go to IDLE.
- Exactly N oRdclk pulses per frame, no extra read.
  - cnt width is clog2(N+1); it never wraps.
- oTxData holds its value from the load cycle until the next load.
  - oNewData is asserted only while oTxData is stable, at least one cycle after the load.
- full is sampled only in IDLE.
  - Changes to full during a frame are ignored.
  - A channel that is still full after its frame is eligible again, but only after the other requesting channels.
- Simultaneous requests are resolved by round-robin from ptr+1.
  - A single requester is re-granted back-to-back.
  - Minimum gap between frames is 1 cycle (DONE to IDLE).
- If txBusy is stuck high, the block waits in TXW indefinitely. There is no timeout.
- Latency: full at edge t in IDLE → oGrant and header on oTxData at t+1 → oNewData high in cycle t+2.

Optional Feature:
- Macro UART_TX_SCHED_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator is cleared at grant and updated with every byte loaded into oTxData, header included.
  - After the N-th data byte, state CSUM loads oTxData with the accumulator, then goes to SEND and GUARD/TXW, then DONE.
  - A frame is N+2 bytes.
- Undefined: no accumulator logic, no CSUM state; a frame is N+1 bytes.

Test Plan:
- Single channel, NCH=4, N=4, full[2]=1, txBusy model 10 cycles per byte, fifo data 0x11..0x14:
  - UART receives A2,11,12,13,14.
  - Exactly 4 oRdclk[2] pulses; oGrant=4'b0100 during the frame.
  - With checksum enabled, a 6th byte 0xA6 follows.
- Contention: full=4'b1011 held, N=2:
  - Grant order 0,1,3,0,1,3.
  - Headers A0,A1,A3,A0…
  - No oRdclk on a non-granted channel.
- txBusy stretch: hold txBusy high 200 cycles after the first data byte:
  - No oNewData or oRdclk during the hold.
  - The frame resumes within 2 cycles of txBusy falling.
- Reset mid-frame: assert rst for 1 cycle during RW1 of byte 2:
  - Next cycle all outputs are 0 and the state is IDLE.
  - With full[0]=1, the next frame starts on channel 0 with a fresh count of N reads.
- Handshake timing: check that oNewData is always exactly 1 cycle wide and that oTxData does not change from the load cycle until 1 cycle after oNewData, across 100 random-busy frames.
- full toggling during a frame: drop full[2] mid-frame:
  - The frame still completes with N reads.
  - The block returns to IDLE and stays idle while full=0.
